// File: rtl/sha3_absorb_ctrl.sv
// rtl/sha3_absorb_ctrl.sv - SHA3-256 absorb/squeeze sequencer
//
// Purpose:
//   Packs a stream of 64-bit little-endian message words into 1088-bit rate
//   blocks and applies pad10*1 with SHA-3 domain bits (0x06 ... 0x80). Launches
//   one Keccak-f[1600] permutation per block on an external round core, then
//   presents the 256-bit digest with a valid/ready handshake.
//
// Optional feature macro: SHA3_ABSORB_BLKCNT_EN
//   When defined, adds o_blk_count[15:0]: permutations launched for the
//   current message, saturating at 16'hFFFF.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_in_valid           message word valid
//   o_in_ready           controller accepts a word this cycle
//   i_in_data            message word, byte i = bits [8i+7:8i]
//   i_in_last            final word of message
//   i_in_bytes           valid bytes in the final word (0..8, >8 treated as 8)
//   o_blk_data           padded rate block for the core to XOR into the state
//   o_blk_init           first block of message: core zeroes state first
//   o_perm_start         one-cycle pulse: absorb o_blk_data and permute
//   i_perm_done          one-cycle pulse from core: permutation complete
//   i_perm_lanes         state bits [255:0] from core
//   o_dig_valid          digest available
//   i_dig_ready          digest consumer accepts
//   o_digest             hash result
//   o_blk_count          (SHA3_ABSORB_BLKCNT_EN only) block counter

module sha3_absorb_ctrl #(
  parameter int RATE   = 1088,
  parameter int WORD   = 64,
  parameter int DIGEST = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WORD-1:0]   i_in_data,
  input  logic              i_in_last,
  input  logic [3:0]        i_in_bytes,
  output logic [RATE-1:0]   o_blk_data,
  output logic              o_blk_init,
  output logic              o_perm_start,
  input  logic              i_perm_done,
  input  logic [DIGEST-1:0] i_perm_lanes,
  output logic              o_dig_valid,
  input  logic              i_dig_ready,
  output logic [DIGEST-1:0] o_digest
`ifdef SHA3_ABSORB_BLKCNT_EN
  ,
  output logic [15:0]       o_blk_count
`endif
);

  localparam int NWORDS = RATE / WORD;
  localparam int RBYTES = RATE / 8;
  localparam int WBYTES = WORD / 8;
  localparam int KW     = $clog2(NWORDS);
  localparam int PW     = $clog2(RBYTES + 1);
  localparam int BW     = $clog2(RATE);
  localparam logic [KW-1:0]   K_LAST   = KW'(NWORDS - 1);
  localparam logic [RATE-1:0] PAD_ONLY = {8'h80, {(RATE-16){1'b0}}, 8'h06};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t            r_state;
  logic [RATE-1:0]   r_blk;
  logic [KW-1:0]     r_k;
  logic              r_first;
  logic              r_final;
  logic              r_pad_pending;
  logic              r_in_ready;
  logic              r_perm_start;
  logic              r_blk_init;
  logic              r_dig_valid;
  logic [DIGEST-1:0] r_digest;

  logic [3:0]        w_n;
  logic [WORD-1:0]   w_word;
  logic [PW-1:0]     w_pad_pos;
  logic [BW-1:0]     w_pad_bit;
  logic              w_no_room;
  logic [RATE-1:0]   w_blk_ins;
  logic [RATE-1:0]   w_blk_last;

  // Next block contents for a non-last word (w_blk_ins) and for the last word
  // with truncation and padding applied (w_blk_last).
  always_comb begin
    w_n = (i_in_bytes > 4'(WBYTES)) ? 4'(WBYTES) : i_in_bytes;

    w_word = '0;
    for (int j = 0; j < WBYTES; j++) begin
      if (j < int'(w_n)) w_word[8*j +: 8] = i_in_data[8*j +: 8];
    end

    w_blk_ins  = r_blk;
    w_blk_last = r_blk;
    for (int i = 0; i < NWORDS; i++) begin
      if (i == int'(r_k)) begin
        w_blk_ins[WORD*i +: WORD]  = i_in_data;
        w_blk_last[WORD*i +: WORD] = w_word;
      end else if (i > int'(r_k)) begin
        w_blk_last[WORD*i +: WORD] = '0;
      end
    end

    // First pad byte lands right after the message; when the block is
    // exactly full there is no room and a pad-only block follows.
    w_pad_pos = PW'(int'(r_k) * WBYTES + int'(w_n));
    w_pad_bit = BW'(int'(w_pad_pos) * 8);
    w_no_room = (int'(w_pad_pos) >= RBYTES);
    if (!w_no_room) begin
      w_blk_last[w_pad_bit +: 8] = w_blk_last[w_pad_bit +: 8] ^ 8'h06;
      w_blk_last[RATE-8 +: 8]    = w_blk_last[RATE-8 +: 8] ^ 8'h80;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_blk         <= '0;
      r_k           <= '0;
      r_first       <= 1'b1;
      r_final       <= 1'b0;
      r_pad_pending <= 1'b0;
      r_in_ready    <= 1'b0;
      r_perm_start  <= 1'b0;
      r_blk_init    <= 1'b0;
      r_dig_valid   <= 1'b0;
      r_digest      <= '0;
    end else begin
      r_perm_start <= 1'b0;
      r_blk_init   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_COLLECT;
          r_in_ready <= 1'b1;
        end

        S_COLLECT: begin
          if (i_in_valid) begin
            if (i_in_last) begin
              r_blk         <= w_blk_last;
              r_final       <= !w_no_room;
              r_pad_pending <= w_no_room;
              r_state       <= S_START;
              r_in_ready    <= 1'b0;
              r_perm_start  <= 1'b1;
              r_blk_init    <= r_first;
            end else if (r_k == K_LAST) begin
              r_blk         <= w_blk_ins;
              r_final       <= 1'b0;
              r_pad_pending <= 1'b0;
              r_state       <= S_START;
              r_in_ready    <= 1'b0;
              r_perm_start  <= 1'b1;
              r_blk_init    <= r_first;
            end else begin
              r_blk <= w_blk_ins;
              r_k   <= r_k + 1'b1;
            end
          end
        end

        S_START: begin
          r_first <= 1'b0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (i_perm_done) begin
            if (r_final) begin
              r_digest    <= i_perm_lanes;
              r_dig_valid <= 1'b1;
              r_state     <= S_OUT;
            end else if (r_pad_pending) begin
              r_blk         <= PAD_ONLY;
              r_final       <= 1'b1;
              r_pad_pending <= 1'b0;
              r_state       <= S_START;
              r_perm_start  <= 1'b1;
              r_blk_init    <= r_first;
            end else begin
              r_blk      <= '0;
              r_k        <= '0;
              r_state    <= S_COLLECT;
              r_in_ready <= 1'b1;
            end
          end
        end

        S_OUT: begin
          if (i_dig_ready) begin
            r_dig_valid <= 1'b0;
            r_first     <= 1'b1;
            r_final     <= 1'b0;
            r_k         <= '0;
            r_blk       <= '0;
            r_state     <= S_COLLECT;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA3_ABSORB_BLKCNT_EN
  logic [15:0] r_blk_count;

  // Cleared by the first word of a new message; increments never coincide
  // with that clear because launches happen outside COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_count <= '0;
    end else if (r_state == S_COLLECT && i_in_valid && r_first && r_k == '0) begin
      r_blk_count <= '0;
    end else if (r_perm_start && r_blk_count != 16'hFFFF) begin
      r_blk_count <= r_blk_count + 16'd1;
    end
  end

  assign o_blk_count = r_blk_count;
`endif

  assign o_in_ready   = r_in_ready;
  assign o_blk_data   = r_blk;
  assign o_blk_init   = r_blk_init;
  assign o_perm_start = r_perm_start;
  assign o_dig_valid  = r_dig_valid;
  assign o_digest     = r_digest;

endmodule

// File: doc/sha3_absorb_ctrl.md
Name: sha3_absorb_ctrl

Overview:
Sequencer for the SHA3-256 absorb/squeeze flow. It accepts a message as a stream of 64-bit little-endian words and packs them into 1088-bit rate blocks. It applies SHA-3 pad10*1 padding with domain bits 0b01 (byte 0x06 … 0x80). It launches one Keccak-f[1600] permutation per block on the external round core, then returns the 256-bit digest with a valid/ready handshake.

Parameters:
RATE, 1088, rate in bits; must be a multiple of WORD
WORD, 64, input word width in bits
DIGEST, 256, digest width in bits; must be ≤ RATE
(localparam NWORDS = RATE/WORD = 17; RBYTES = RATE/8 = 136)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  message word valid
in_ready  out  1  controller accepts word this cycle
in_data  in  64  message word; byte i = bits [8i+7:8i]
in_last  in  1  final word of message
in_bytes  in  4  valid bytes in final word, 0..8; ignored unless in_last
blk_data  out  RATE  padded rate block to XOR into state lanes [1087:0]
blk_init  out  1  first block of message; core zeroes state before XOR
perm_start  out  1  one-cycle pulse: absorb blk_data and run 24 rounds
perm_done  in  1  one-cycle pulse from core: permutation complete
perm_lanes  in  DIGEST  state bits [255:0] from core
dig_valid  out  1  digest available
dig_ready  in  1  digest consumer accepts
digest  out  DIGEST  hash result

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, perm_start=0, dig_valid=0, blk_init=0, blk_data=0, digest=0, word index=0, first-block flag=1. A reset mid-permutation abandons the message. Any perm_done arriving before the next perm_start is ignored.
- States: IDLE -> COLLECT (next cycle after reset release); COLLECT -> START; START -> WAIT; WAIT -> COLLECT or OUT; OUT -> COLLECT.
- COLLECT: in_ready=1. Handshake on in_valid&in_ready; at most one word per cycle. The word goes to blk_data[64k+63:64k], where k is the word index.
  - Non-last word, k<16: k++.
  - Non-last word, k=16: block full; go to START, pad_pending=0.
  - Last word, n=in_bytes: keep bytes 0..n-1 and zero bytes n..7. Byte 8k+n ^= 0x06 and byte 135 ^= 0x80. If 8k+n=135, that byte is 0x86. Clear words k+1..16, go to START, final=1.
  - Last word, k=16 and n=8: the block is full with no room for padding. Launch it with final=0 and pad_pending=1.
- START: in_ready=0. perm_start=1 for exactly one cycle. blk_init = first-block flag, and the flag is then cleared. blk_data is held stable from START until perm_done.
- WAIT: in_ready=0; hold until perm_done.
  - final=1: capture digest=perm_lanes, go to OUT.
  - pad_pending=1: load a pad-only block (byte0=0x06, byte135=0x80, rest 0), set final=1, go to START.
  - Otherwise: clear blk_data, k=0, go to COLLECT.
- OUT: dig_valid=1, digest stable until dig_valid&dig_ready. Then dig_valid=0, first-block flag=1, k=0, clear blk_data, go to COLLECT. in_ready=0 in OUT: no overlap of the next message.
- in_bytes>8 with in_last is treated as 8.
- perm_done outside WAIT is ignored.
- Latency: perm_start occurs 1 cycle after the accepting handshake of the block's final word. dig_valid rises 1 cycle after the final perm_done.

Optional Feature:
SHA3_ABSORB_BLKCNT_EN
- Defined: adds output blk_count[15:0].
  - Reset to 0 on rst_n and when a new message's first word is accepted.
  - Increments on each perm_start, saturating at 16'hFFFF.
  - Held stable while dig_valid.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. Empty message: one word with in_last=1, in_bytes=0 -> one perm_start with blk_init=1; blk_data[7:0]=8'h06, blk_data[1087:1080]=8'h80, all other bits 0.
2. "abc": in_data=64'h0000_0000_0063_6261, in_last=1, in_bytes=3 -> blk_data[31:0]=32'h0663_6261, byte135=0x80. Core returns perm_lanes=X -> digest=X, dig_valid held until dig_ready.
3. 135-byte message (17th word, in_bytes=7) -> single block with byte135=8'h86, exactly one perm_start.
4. 136-byte message (17 full words, last with in_bytes=8) -> two perm_starts: first with blk_init=1 and pure data; second with blk_init=0 and the pad-only block (0x06 at byte0, 0x80 at byte135).
5. 200-byte message with in_valid gaps and dig_ready held low 5 cycles -> in_ready=0 during START/WAIT/OUT, no word lost, digest constant for 5 cycles. Next message restarts with blk_init=1.
6. rst_n pulsed low during WAIT, then a stray perm_done -> all outputs 0 immediately, no perm_start or dig_valid from the stray pulse. A subsequent "abc" hashes correctly.
